// File: rtl/bist_addr_gen.sv
// BIST march address generator: bounded up/down index sequencer with linear, Gray and mirrored-pair maps.
// Define BIST_ADDR_GRAY_EN to build the Gray map for mode 01; otherwise mode 01 behaves as linear.
module bist_addr_gen #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              preset,
   input  logic              en,
   input  logic              up_down,
   input  logic [1:0]        mode,
   input  logic [ADDR_W-1:0] lo_bound,
   input  logic [ADDR_W-1:0] hi_bound,
   output logic [ADDR_W-1:0] address,
   output logic              carry,
   output logic              last,
   output logic              cfg_err
);

   typedef enum logic [1:0] {
      MODE_LINEAR = 2'b00,
      MODE_GRAY   = 2'b01,
      MODE_MIRROR = 2'b10,
      MODE_RSVD   = 2'b11
   } mode_e;

   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] lo_q, lo_d;
   logic [ADDR_W-1:0] hi_q, hi_d;
   mode_e             mode_q, mode_d;
   logic              phase_q, phase_d;
   logic              carry_q, carry_d;
   logic              cfg_err_q, cfg_err_d;

   logic [ADDR_W-1:0] term_idx;
   logic [ADDR_W-1:0] start_idx;

   assign term_idx  = up_down ? hi_q : lo_q;
   assign start_idx = up_down ? lo_q : hi_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q     <= '0;
         lo_q      <= '0;
         hi_q      <= '1;
         mode_q    <= MODE_LINEAR;
         phase_q   <= 1'b0;
         carry_q   <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
         cnt_q     <= cnt_d;
         lo_q      <= lo_d;
         hi_q      <= hi_d;
         mode_q    <= mode_d;
         phase_q   <= phase_d;
         carry_q   <= carry_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      cnt_d     = cnt_q;
      lo_d      = lo_q;
      hi_d      = hi_q;
      mode_d    = mode_q;
      phase_d   = phase_q;
      carry_d   = 1'b0;
      cfg_err_d = cfg_err_q;

      if (preset) begin
         lo_d      = lo_bound;
         hi_d      = hi_bound;
         mode_d    = mode_e'(mode);
         phase_d   = 1'b0;
         cfg_err_d = (lo_bound > hi_bound);
         if (lo_bound > hi_bound || up_down) begin
            cnt_d = lo_bound;
         end else begin
            cnt_d = hi_bound;
         end
      end else if (en && !cfg_err_q) begin
         // Mirrored-pair mode emits two addresses per index, so the index only moves on the second.
         if (mode_q == MODE_MIRROR && !phase_q) begin
            phase_d = 1'b1;
         end else begin
            phase_d = 1'b0;
            if (cnt_q == term_idx) begin
               cnt_d   = start_idx;
               carry_d = 1'b1;
            end else if (up_down) begin
               cnt_d = cnt_q + 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
      end
   end

   always_comb begin
      address = cnt_q;
      unique case (mode_q)
         MODE_MIRROR: begin
            // The partner lo+hi-cnt always lies inside the window, so truncating the wide sum is exact.
            if (phase_q) begin
               address = ADDR_W'({1'b0, lo_q} + {1'b0, hi_q} - {1'b0, cnt_q});
            end
         end
`ifdef BIST_ADDR_GRAY_EN
         MODE_GRAY:   address = cnt_q ^ (cnt_q >> 1);
`else
         MODE_GRAY:   address = cnt_q;
`endif
         default:     address = cnt_q;
      endcase
   end

   assign last    = !reset &&
                    (cfg_err_q || ((cnt_q == term_idx) && (mode_q != MODE_MIRROR || phase_q)));
   assign carry   = carry_q;
   assign cfg_err = cfg_err_q;

endmodule

// File: doc/bist_addr_gen.md
# bist_addr_gen

Parametrised BIST march address generator: a bounded up/down address sequencer with selectable address orderings (linear, Gray, mirrored-pair) and wrap and terminal flags. It sits between the BIST controller FSM and the memory-under-test address port. The controller loads a window with `preset`, then advances one address per `en` cycle. It reverses direction between march elements with `up_down` and detects element end from `last` and `carry`.

## Interface
- `ADDR_W`, default 8: address width; the sweep covers any window inside 0..2^ADDR_W-1.
- `clk  in  1`: single clock; all state updates on the rising edge.
- `reset  in  1`: asynchronous, active-high reset of all state.
- `preset  in  1`: synchronous load of the window, mode and start index.
- `en  in  1`: advance one step this cycle.
- `up_down  in  1`: 1 = ascending, 0 = descending. Live input, sampled at every step.
- `mode  in  2`: 00 linear, 01 Gray, 10 mirrored-pair, 11 reserved (behaves as 00). Latched at `preset`.
- `lo_bound  in  ADDR_W`: window low index. Latched at `preset`.
- `hi_bound  in  ADDR_W`: window high index. Latched at `preset`.
- `address  out  ADDR_W`: current memory address.
- `carry  out  1`: registered one-cycle pulse after a wrap step.
- `last  out  1`: current address is the final one of the sweep in the current direction.
- `cfg_err  out  1`: latched window error (lo_bound > hi_bound).

## Operation
- **State registers:** `cnt` (ADDR_W), `phase` (1), `lo_q`, `hi_q`, `mode_q`, `carry`, `cfg_err`.
- **Reset values:** `cnt`=0, `phase`=0, `lo_q`=0, `hi_q`=all ones, `mode_q`=00, `carry`=0, `cfg_err`=0. While `reset` is high, `address`=0 and `last`=0.
- **Preset (priority over `en`):**
  - Latch the bounds and mode.
  - Load `cnt` = `up_down` ? `lo_bound` : `hi_bound`, and set `phase`=0.
  - `cfg_err` = (`lo_bound` > `hi_bound`).
  - When `cfg_err` is set, `cnt` = `lo_bound`, stepping is suppressed, and `last`=1 until the next valid preset.
- **Terminal index:** T = `up_down` ? `hi_q` : `lo_q`. Start index: S = `up_down` ? `lo_q` : `hi_q`.
- **Step rule (`en`=1, no preset, no error):**
  - Modes 00 and 01: if `cnt`==T, then `cnt`<=S and `carry`<=1. Otherwise `cnt` moves ±1 and `carry`<=0.
  - Mode 10: if `phase`=0, set `phase`<=1. If `phase`=1, set `phase`<=0 and apply the `cnt` rule above.
- **`en`=0:** all state holds and `carry`<=0.
- **Address map:**
  - Mode 00: `address` = `cnt`.
  - Mode 01: `address` = `cnt` ^ (`cnt`>>1).
  - Mode 10: `address` = `phase` ? (`lo_q`+`hi_q`−`cnt`) : `cnt`. The sum is computed at ADDR_W+1 bits, and the result is always inside the window.
  - Bounds always apply to the binary index `cnt`, never to the mapped address.
- **`last`:** (`cnt`==T) && (`mode_q`!=10 || `phase`==1), or `cfg_err`. It is combinational from state and `up_down`; there is no other input-to-output path.
- **Direction change mid-sweep:** the next step simply moves toward the new T. No reload occurs and `phase` is preserved.

## Timing
- **Step latency:** `address` reflects a step or preset one cycle after the `clk` edge that samples it. There are no bubbles, and one address is produced per enabled cycle.
- **`carry`:** high for exactly the cycle following a wrap edge, coincident with `address` showing the start address.
- **Simultaneous `preset` and `en`:** preset only. `carry`=0 and `cnt` does not step.
- **Asynchronous reset mid-sweep:** takes effect immediately. Operation resumes only after a `preset`; `en` without a preset walks the reset window 0..max.
- **Single-entry window (lo==hi):** every step is a wrap, so `carry` pulses on every enabled cycle and `last` stays 1. In mode 10 this happens every second enabled cycle.

## Configuration
- `BIST_ADDR_GRAY_EN` defined: mode 01 produces Gray addresses as specified.
- `BIST_ADDR_GRAY_EN` undefined: the Gray XOR logic is omitted and mode 01 behaves exactly as mode 00. All other behaviour is unchanged.

## Test plan
- **Reset, then basic up/down sweep:** reset; preset lo=0, hi=255, mode 00, up; en for 256 cycles.
  - Response: `address` 0..255, `last`=1 only at 255, then wraps to 0 with `carry`=1 for one cycle.
  - Then `up_down`=0: `address` goes 255 at the next step, then 254 down to 0.
- **Window and direction flip:** preset lo=0x10, hi=0x13, up; step 0x10,0x11; set `up_down`=0.
  - Response: 0x10, 0x11, 0x10, then wrap to 0x13 with a `carry` pulse.
- **Mirrored pair:** preset lo=2, hi=5, mode 10, up.
  - Response: `address` 2,5,3,4,4,3,5,2, then 2 with `carry`=1; `last`=1 on the eighth address.
- **Gray mode:** preset 0..7, mode 01.
  - With the macro: 0,1,3,2,6,7,5,4.
  - Without the macro: 0..7.
- **Preset priority and bad window:** assert `preset` and `en` together → no step, `carry`=0.
  - Then preset lo=9, hi=3 → `cfg_err`=1, `address`=9, `last`=1, and `en` does not move it.
- **Async reset mid-sweep:** pulse `reset` between clock edges during a sweep.
  - Response: `address`=0, `carry`=0, `last`=0, and `cfg_err`=0 immediately, without waiting for a clock edge.
